// File: rtl/watch_set_ctrl.sv
// Key-driven time-setting controller: synchronises and debounces MODE/UP/EXIT,
// auto-repeats UP, and sequences RUN / SET_HOUR / SET_MIN with registered strobes.
module watch_set_ctrl #(
  parameter int CLK_FRE     = 27_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int TIMEOUT_S   = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] key,
  output logic       run_en,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic [2:0] mode
);

  localparam int TICK_DIV = CLK_FRE / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW       = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int MSW      = $clog2(1000);
  localparam int SW       = $clog2(TIMEOUT_S + 1);

  // state    | meaning
  // S_RUN    | time counter runs, only MODE is honoured
  // S_HOUR   | counter frozen, UP bumps the hour
  // S_MIN    | counter frozen, UP bumps the minute; leaving clears seconds
  typedef enum logic [2:0] {
    S_RUN  = 3'b000,
    S_HOUR = 3'b001,
    S_MIN  = 3'b010
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [2:0]      r_sync1, r_sync2, r_deb;
  logic [DW-1:0]   r_deb_cnt [3];
  logic [2:0]      w_deb_upd, w_press;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_rep_phase, w_up_held, w_rep;
  logic [HW-1:0]   w_hold_last;
  logic [MSW-1:0]  r_ms_cnt;
  logic [SW-1:0]   r_sec_cnt;
  logic            w_timeout;
  logic            w_ev_exit, w_ev_mode, w_ev_up, w_ev_any;
  logic            w_hour_nxt, w_min_nxt, w_sec_nxt;
  logic            r_hour_inc, r_min_inc, r_sec_clr, r_run_en;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_deb_upd = '0;
    w_press   = '0;
    for (int i = 0; i < 3; i++) begin
      w_deb_upd[i] = (r_sync2[i] != r_deb[i]) && w_tick &&
                     (r_deb_cnt[i] == DW'(DEBOUNCE_MS - 1));
      w_press[i]   = w_deb_upd[i] && r_deb[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_deb <= '1;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_deb_upd[i]) begin
          r_deb_cnt[i] <= '0;
          r_deb[i]     <= r_sync2[i];
        end else if (w_tick) begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // First repeat waits LONG_MS from the press, later ones REPEAT_MS apart.
  assign w_up_held   = ~r_deb[1];
  assign w_hold_last = r_rep_phase ? HW'(REPEAT_MS - 1) : HW'(LONG_MS - 1);
  assign w_rep       = w_up_held && w_tick && (r_hold_cnt == w_hold_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
    end else if (!w_up_held) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b1;
    end else if (w_tick) begin
      r_hold_cnt  <= r_hold_cnt + 1'b1;
    end
  end

  assign w_ev_exit = w_press[2];
  assign w_ev_mode = w_press[0] && !w_press[2];
  assign w_ev_up   = (w_press[1] || w_rep) && !w_press[0] && !w_press[2];
  assign w_ev_any  = w_press[2] || w_press[0] || w_press[1] || w_rep;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ms_cnt  <= '0;
      r_sec_cnt <= '0;
    end else if (r_state == S_RUN || w_ev_any) begin
      r_ms_cnt  <= '0;
      r_sec_cnt <= '0;
    end else if (w_tick) begin
      if (r_ms_cnt == MSW'(999)) begin
        r_ms_cnt <= '0;
        if (r_sec_cnt != SW'(TIMEOUT_S)) r_sec_cnt <= r_sec_cnt + 1'b1;
      end else begin
        r_ms_cnt <= r_ms_cnt + 1'b1;
      end
    end
  end

  assign w_timeout = w_tick && (r_ms_cnt == MSW'(999)) &&
                     (r_sec_cnt == SW'(TIMEOUT_S - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = 1'b0;
    w_min_nxt   = 1'b0;
    w_sec_nxt   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_ev_mode) w_state_nxt = S_HOUR;
      end
      S_HOUR: begin
        if (w_ev_exit)      w_state_nxt = S_RUN;
        else if (w_ev_mode) w_state_nxt = S_MIN;
        else if (w_ev_up)   w_hour_nxt  = 1'b1;
        else if (w_timeout) w_state_nxt = S_RUN;
      end
      S_MIN: begin
        if (w_ev_exit || w_ev_mode || w_timeout) begin
          w_state_nxt = S_RUN;
          w_sec_nxt   = 1'b1;
        end else if (w_ev_up) begin
          w_min_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hour_inc <= 1'b0;
      r_min_inc  <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_run_en   <= 1'b1;
    end else begin
      r_hour_inc <= w_hour_nxt;
      r_min_inc  <= w_min_nxt;
      r_sec_clr  <= w_sec_nxt;
      r_run_en   <= (w_state_nxt == S_RUN);
    end
  end

  assign hour_inc = r_hour_inc;
  assign min_inc  = r_min_inc;
  assign sec_clr  = r_sec_clr;
  assign run_en   = r_run_en;
  assign mode     = r_state;

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Key-driven time-setting controller for the digital-clock datapath.
- Synchronises and debounces the three board keys.
- Runs a mode FSM (RUN / SET_HOUR / SET_MIN) and issues single-cycle increment and clear strobes to the time counter.
- Drives a mode code to the display controller for digit blinking, and a run enable that freezes counting while time is being set.

Parameters:
- CLK_FRE, 27_000_000, input clock frequency in Hz; ms tick period = CLK_FRE/1000 clocks (must be >= 1000).
- DEBOUNCE_MS, 20, ms a raw key level must be stable before it is accepted.
- LONG_MS, 1000, ms a key must be held before auto-repeat starts.
- REPEAT_MS, 200, auto-repeat interval in ms.
- TIMEOUT_S, 30, seconds without any accepted press before a set mode returns to RUN.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- key  input  3  raw push-buttons, active-low (pressed = 0): key[0] MODE, key[1] UP, key[2] EXIT
- run_en  output  1  1 = time counter may advance; 0 = frozen
- hour_inc  output  1  one-cycle strobe: hour +1 (wrap handled by counter)
- min_inc  output  1  one-cycle strobe: minute +1
- sec_clr  output  1  one-cycle strobe: clear seconds / prescaler
- mode  output  3  3'b000 RUN, 3'b001 SET_HOUR, 3'b010 SET_MIN, other codes never driven

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low.
  - Every flop clears on rstn = 0. Synchronisers and debounced levels reset to 1 (released).
- Reset values: run_en = 1, hour_inc = min_inc = sec_clr = 0, mode = 3'b000.
  - Asserting reset mid-set aborts the set, drops to RUN, and emits no strobe.
- ms tick:
  - Free-running counter 0..CLK_FRE/1000-1.
  - Produces a one-cycle tick on wrap.
- Key conditioning (per key, independent):
  - 2-FF synchroniser.
  - Debounce counter counts ticks while the synchronised level differs from the debounced level; it clears when the levels match.
  - Debounced level updates when the counter reaches DEBOUNCE_MS.
  - Press event = debounced 1 -> 0 transition, one cycle wide.
  - Releases generate no events.
- Auto-repeat (UP only):
  - Hold counter in ticks starts at the press.
  - At LONG_MS held, then every REPEAT_MS while still held, one extra UP event.
  - Release resets the hold counter.
- Simultaneous events in the same cycle: priority EXIT > MODE > UP; lower-priority events that cycle are discarded.
- FSM transitions:
  - RUN:
    - MODE -> SET_HOUR.
    - UP and EXIT are ignored.
  - SET_HOUR:
    - UP -> hour_inc.
    - MODE -> SET_MIN.
    - EXIT -> RUN.
  - SET_MIN:
    - UP -> min_inc.
    - MODE -> RUN with sec_clr.
    - EXIT -> RUN with sec_clr.
  - Timeout: in SET_HOUR or SET_MIN, a seconds counter (1000 ticks = 1 s) clears on every accepted event and on state entry. At TIMEOUT_S -> RUN, with sec_clr only if leaving SET_MIN.
- Output timing:
  - All outputs are registered.
  - Strobes and the mode/run_en change appear exactly one clock after the cycle in which the press event is high.
  - Strobes are high for exactly one clock.
  - mode and run_en update in the same clock as the accompanying strobe.
  - run_en = 1 iff mode == RUN.
  - Only one of hour_inc / min_inc / sec_clr may be high in any cycle.
- Counter widths: sized by $clog2 of their parameter maxima; counters saturate/clear and never wrap into false events.

Test Plan:
- Reset, then idle 100 ms with keys = 3'b111 -> run_en = 1, mode = 0, no strobes.
- Key-handling checks:
  - Glitch key[0] low for 5 ms -> no mode change.
  - Hold low 25 ms -> mode = 001 and run_en = 0 one clk after the debounced event (~20 ms after press + sync).
- In SET_HOUR, three 50 ms UP presses -> exactly 3 hour_inc pulses, each 1 clk wide; press MODE -> mode = 010.
- In SET_MIN, hold UP 1.65 s -> 1 (press) + 4 (repeats at 1.0/1.2/1.4/1.6 s) = 5 min_inc pulses; then EXIT -> one sec_clr, mode = 000, run_en = 1.
- MODE and UP debounce in the same cycle while in SET_HOUR -> mode = 010, no hour_inc.
- Enter SET_MIN, no keys for 30 s -> return to RUN with a single sec_clr.
- Assert rstn mid-hold -> immediate reset values, no strobe after release.
- Use CLK_FRE = 1000 in simulation for speed.
